// File: rtl/shift_issue_pipe_if.sv
// Request/response bundle for shift_issue_pipe: issue handshake in, result handshake out.
// master = producer/consumer side (testbench or upstream logic), slave = the pipe itself.
interface shift_issue_pipe_if #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
);
   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_W-1:0]    in_a;
   logic [SHAMT_W-1:0]   in_shamt;
   logic [1:0]           in_op;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_W-1:0]    out_result;
   logic                 out_op_err;

   modport master (
      output in_valid, in_a, in_shamt, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_op_err
   );

   modport slave (
      input  in_valid, in_a, in_shamt, in_op, out_ready,
      output in_ready, out_valid, out_result, out_op_err
   );
endinterface

// File: rtl/shift_issue_pipe.sv
// Two-stage issue/capture controller wrapped around the external right-only 32-bit shift chain.
// Optional feature: define SHIFT_PERF_CNT_EN to add the saturating perf_cnt handshake counter port.
module shift_issue_pipe #(
   parameter int DATA_W  = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst,
   shift_issue_pipe_if.slave  bus,
   output logic [DATA_W-1:0]  stage_in,
   output logic [SHAMT_W-1:0] stage_en,
   output logic               stage_fill,
   input  logic [DATA_W-1:0]  stage_out
`ifdef SHIFT_PERF_CNT_EN
   ,
   output logic [31:0]        perf_cnt
`endif
);

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_RSV = 2'b10,
      OP_SRA = 2'b11
   } op_e;

   function automatic logic [DATA_W-1:0] bitrev(input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) begin
         r[i] = v[DATA_W-1-i];
      end
      return r;
   endfunction

   logic               s1_valid;
   logic [DATA_W-1:0]  s1_a;
   logic [SHAMT_W-1:0] s1_shamt;
   op_e                s1_op;

   logic               s2_valid;
   logic [DATA_W-1:0]  s2_result;
   logic               s2_op_err;

   logic               accept;
   logic               s2_adv;
   logic [DATA_W-1:0]  chain_result;

   // S1 may move on when S2 is empty or being drained this cycle; in_ready never looks at in_valid.
   assign s2_adv       = s1_valid && (!s2_valid || bus.out_ready);
   assign bus.in_ready = !s1_valid || s2_adv;
   assign accept       = bus.in_valid && bus.in_ready;

   // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
   always_comb begin
      stage_in     = s1_a;
      stage_en     = s1_shamt;
      stage_fill   = 1'b0;
      chain_result = stage_out;
      unique case (s1_op)
         OP_SLL: begin
            stage_in     = bitrev(s1_a);
            chain_result = bitrev(stage_out);
         end
         OP_SRA: stage_fill = s1_a[DATA_W-1];
         OP_RSV: stage_en   = '0;
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_shamt <= '0;
         s1_op    <= OP_SLL;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_a     <= bus.in_a;
         s1_shamt <= bus.in_shamt;
         s1_op    <= op_e'(bus.in_op);
      end else if (s2_adv) begin
         s1_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         s2_result <= '0;
         s2_op_err <= 1'b0;
      end else if (s2_adv) begin
         s2_valid  <= 1'b1;
         s2_result <= chain_result;
         s2_op_err <= (s1_op == OP_RSV);
      end else if (bus.out_ready) begin
         s2_valid  <= 1'b0;
      end
   end

   assign bus.out_valid  = s2_valid;
   assign bus.out_result = s2_result;
   assign bus.out_op_err = s2_op_err;

`ifdef SHIFT_PERF_CNT_EN
   // Counts delivered results; sticks at all-ones instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_cnt <= '0;
      end else if (s2_valid && bus.out_ready && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_shift_issue_pipe.sv
// Scoreboard bench for shift_issue_pipe: accepted requests are modelled with plain shift
// operators and queued; a negedge monitor pops and compares each delivered result.
module tb_shift_issue_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] stage_in;
   logic [4:0]  stage_en;
   logic        stage_fill;
   logic [31:0] stage_out;
`ifdef SHIFT_PERF_CNT_EN
   logic [31:0] perf_cnt;
`endif

   typedef struct {
      logic [31:0] res;
      logic        err;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   hs_cnt   = 0;
   int   cyc;

   shift_issue_pipe_if bus ();

   shift_issue_pipe dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .stage_in   (stage_in),
      .stage_en   (stage_en),
      .stage_fill (stage_fill),
      .stage_out  (stage_out)
`ifdef SHIFT_PERF_CNT_EN
      ,
      .perf_cnt   (perf_cnt)
`endif
   );

   always #5 clk = ~clk;

   // External 16->8->4->2->1 chain collapsed to one right shift by the enabled amount.
   always_comb begin
      stage_out = stage_in >> stage_en;
      if (stage_fill) stage_out = ~((~stage_in) >> stage_en);
   end

   function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] sh,
                                             input logic [1:0] op);
      case (op)
         2'b00:   return a << sh;
         2'b01:   return a >> sh;
         2'b11:   return 32'($signed(a) >>> sh);
         default: return a;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, wanted %h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard producer: every accepted request pushes its expected result.
   always @(negedge clk) begin
      if (!rst && bus.in_valid && bus.in_ready)
         q.push_back('{res: ref_shift(bus.in_a, bus.in_shamt, bus.in_op),
                       err: (bus.in_op == 2'b10)});
   end

   // Monitor: compares whenever a result handshake is about to happen.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus.out_valid && bus.out_ready) begin
         hs_cnt++;
         if (q.size() == 0) begin
            check("spurious_out", 32'(q.size()), 32'd1);
         end else begin
            e = q.pop_front();
            check("result", bus.out_result, e.res);
            check("op_err", {31'd0, bus.out_op_err}, {31'd0, e.err});
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_a     = $urandom;
      bus.in_shamt = 5'($urandom_range(0, 31));
      bus.in_op    = 2'($urandom_range(0, 3));
   endtask

   // Offers one request and returns after the accepting edge (+1); cycles = edges waited.
   task automatic send(input logic [31:0] a, input logic [4:0] sh, input logic [1:0] op,
                       input bit rnd_ready, output int cycles);
      bit done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = a;
      bus.in_shamt = sh;
      bus.in_op    = op;
      cycles = 0;
      while (!done && cycles < 200) begin
         if (rnd_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         done = bus.in_ready;
         @(posedge clk);
         #1;
         cycles++;
      end
      check("accept_timeout", {31'd0, done}, 32'd1);
   endtask

   task automatic drain();
      int n = 0;
      idle();
      bus.out_ready = 1'b1;
      while ((q.size() != 0 || bus.out_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", 32'(n < 100), 32'd1);
   endtask

   initial begin
      logic [31:0] held;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      idle();
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
      check("rst_out_result", bus.out_result, 32'd0);
      check("rst_op_err", {31'd0, bus.out_op_err}, 32'd0);
      check("rst_stage", {stage_in[26:0], stage_en}, 32'd0);
      check("rst_fill", {31'd0, stage_fill}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // SRL latency: S1 after the accepting edge, out_valid one edge later.
      send(32'h8000_0000, 5'd31, 2'b01, 1'b0, cyc);
      idle();
      check("lat_s1_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("srl_stage_in", stage_in, 32'h8000_0000);
      check("srl_stage_en", {27'd0, stage_en}, 32'd31);
      @(posedge clk);
      #1;
      check("lat_s2_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("srl_direct", bus.out_result, 32'h0000_0001);
      drain();

      send(32'h8000_0000, 5'd4, 2'b11, 1'b0, cyc);
      idle();
      check("sra_fill", {31'd0, stage_fill}, 32'd1);
      send(32'h0000_0001, 5'd31, 2'b00, 1'b0, cyc);
      idle();
      check("sll_stage_in", stage_in, 32'h8000_0000);
      drain();

      // Back-to-back SLL: every request accepted on its first edge.
      for (int i = 0; i < 8; i++) begin
         send(32'h1, 5'(i), 2'b00, 1'b0, cyc);
         check("b2b_in_ready", 32'(cyc), 32'd1);
      end
      drain();

      // Backpressure: two accepted, third stalls while S2 holds its result.
      bus.out_ready = 1'b0;
      send(32'h0000_00F0, 5'd4, 2'b01, 1'b0, cyc);
      send(32'h0000_0F00, 5'd8, 2'b01, 1'b0, cyc);
      bus.in_valid = 1'b1;
      bus.in_a     = 32'h0000_F000;
      bus.in_shamt = 5'd12;
      bus.in_op    = 2'b01;
      held = bus.out_result;
      check("bp_held_value", held, 32'h0000_000F);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
         check("bp_out_held", bus.out_result, held);
      end
      bus.out_ready = 1'b1;
      send(32'h0000_F000, 5'd12, 2'b01, 1'b0, cyc);
      drain();

      // Reserved op passes the operand through with the error flag.
      send(32'hDEAD_BEEF, 5'd9, 2'b10, 1'b0, cyc);
      idle();
      check("rsv_stage_en", {27'd0, stage_en}, 32'd0);
      drain();

`ifdef SHIFT_PERF_CNT_EN
      check("perf_before_rst", perf_cnt, 32'(hs_cnt));
`endif

      // Reset with both stages full drops everything at once.
      bus.out_ready = 1'b0;
      send(32'h1234_5678, 5'd3, 2'b00, 1'b0, cyc);
      send(32'h8765_4321, 5'd5, 2'b11, 1'b0, cyc);
      idle();
      check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
      check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      q.delete();
      hs_cnt = 0;
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef SHIFT_PERF_CNT_EN
      check("perf_after_rst", perf_cnt, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("post_rst_quiet", {31'd0, bus.out_valid}, 32'd0);
      end

      // Randomised traffic with random backpressure and idle gaps.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            idle();
            repeat ($urandom_range(1, 3)) begin
               bus.out_ready = 1'($urandom_range(0, 1));
               @(posedge clk);
               #1;
            end
         end
         send($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1, cyc);
      end
      drain();
      check("final_queue_empty", 32'(q.size()), 32'd0);
`ifdef SHIFT_PERF_CNT_EN
      check("perf_final", perf_cnt, 32'(hs_cnt));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
